// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: RV32 load/store width codes,
// the controller state enum and small decode helpers.
// Optional feature macro: LSU_MISALIGN_SPLIT_EN (used by lsu_ctrl).
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    // Access size in bytes; low two funct3 bits carry the width for all
    // legal codes (B/BU -> 1, H/HU -> 2, W -> 4).
    function automatic logic [2:0] access_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Stores only have B/H/W; loads additionally have BU/HU.
    function automatic logic funct3_illegal(input logic store, input logic [2:0] funct3);
        if (store) begin
            return funct3 > F3_W;
        end
        return (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
    endfunction

    // True when the byte offset is not a multiple of the access size.
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3[1:0])
            2'd0:    return 1'b0;
            2'd1:    return off[0];
            default: return |off;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// -----------------------------------------------------------------------------
// lsu_ctrl_if
// Bundles the request/response handshake and the data-RAM access port of the
// load/store unit.
//   master : the side that issues requests, consumes responses and models
//            the RAM (drives req_*, resp_ready, dram_dout)
//   slave  : the load/store unit itself (drives req_ready, resp_*, dram_*)
// -----------------------------------------------------------------------------
interface lsu_ctrl_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_store;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;

    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;

    logic [AW-1:0] dram_addr;
    logic [DW-1:0] dram_wdat;
    logic          dram_we;
    logic [3:0]    dram_we_byte;
    logic          dram_rd;
    logic [DW-1:0] dram_dout;

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata,
        output resp_ready, dram_dout,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  dram_addr, dram_wdat, dram_we, dram_we_byte, dram_rd
    );

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata,
        input  resp_ready, dram_dout,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output dram_addr, dram_wdat, dram_we, dram_we_byte, dram_rd
    );
endinterface

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Combinational byte-lane alignment for the load/store unit.
//   funct3    in  3   width/sign code
//   off       in  2   byte offset inside the first word
//   wdata     in  32  LSB-justified store data
//   hi, lo    in  32  second / first RAM word of a load
//   lane_mask out 8   byte enables over two consecutive words
//   wdata_sh  out 64  store data moved onto its byte lanes
//   rdata_ext out 32  load result, shifted down and sign/zero extended
// -----------------------------------------------------------------------------
module lsu_align (
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [7:0]  lane_mask,
    output logic [63:0] wdata_sh,
    output logic [31:0] rdata_ext
);
    import lsu_pkg::*;

    logic [4:0]  bit_off;
    logic [7:0]  base_mask;
    logic [31:0] rdata_w;

    assign bit_off = {off, 3'b000};

    always_comb begin
        case (access_size(funct3))
            3'd1:    base_mask = 8'h01;
            3'd2:    base_mask = 8'h03;
            default: base_mask = 8'h0F;
        endcase
    end

    assign lane_mask = base_mask << off;
    assign wdata_sh  = {32'd0, wdata} << bit_off;
    // Only the low word of the realigned pair is ever needed.
    assign rdata_w   = 32'({hi, lo} >> bit_off);

    always_comb begin
        case (funct3)
            F3_B:    rdata_ext = {{24{rdata_w[7]}}, rdata_w[7:0]};
            F3_H:    rdata_ext = {{16{rdata_w[15]}}, rdata_w[15:0]};
            F3_BU:   rdata_ext = {24'd0, rdata_w[7:0]};
            F3_HU:   rdata_ext = {16'd0, rdata_w[15:0]};
            default: rdata_ext = rdata_w;
        endcase
    end
endmodule

// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl
// Load/store unit in front of the data RAM. Accepts one request at a time,
// performs one or two word accesses, and returns a registered, extended load
// result (0 for stores) with an error flag.
//   clk  in   clock, rising edge
//   rst  in   synchronous active-high reset
//   bus  slave modport of lsu_ctrl_if:
//        req_valid/req_ready/req_store/req_funct3/req_addr/req_wdata
//        resp_valid/resp_ready/resp_rdata/resp_err
//        dram_addr/dram_wdat/dram_we/dram_we_byte/dram_rd/dram_dout
// Optional feature: define LSU_MISALIGN_SPLIT_EN to split word-crossing
// accesses into two word accesses; without it any access whose offset is not
// a multiple of its size is rejected with resp_err.
// -----------------------------------------------------------------------------
module lsu_ctrl #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input logic       clk,
    input logic       rst,
    lsu_ctrl_if.slave bus
);
    import lsu_pkg::*;

    lsu_state_t    state_q, state_d;
    logic          store_q, store_d;
    logic [2:0]    f3_q, f3_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] lo_q, lo_d;
    logic          resp_valid_q, resp_valid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [7:0]    lane_mask;
    logic [63:0]   wdata_sh;
    logic [31:0]   rdata_ext;
    logic [31:0]   align_hi;
    logic [31:0]   align_lo;
    logic [AW-1:0] word_addr;
    logic          crossing;
    logic          req_reject;

    // While a RAM read is in flight the live RAM output feeds the aligner so
    // the result can be registered on the same edge that ends the access.
    assign align_lo  = (state_q == ACC0) ? bus.dram_dout : lo_q;
    assign align_hi  = (state_q == ACC1) ? bus.dram_dout : '0;
    assign word_addr = {addr_q[AW-1:2], 2'b00};

    lsu_align u_align (
        .funct3    (f3_q),
        .off       (addr_q[1:0]),
        .wdata     (wdata_q),
        .hi        (align_hi),
        .lo        (align_lo),
        .lane_mask (lane_mask),
        .wdata_sh  (wdata_sh),
        .rdata_ext (rdata_ext)
    );

`ifdef LSU_MISALIGN_SPLIT_EN
    assign crossing   = |lane_mask[7:4];
    assign req_reject = funct3_illegal(bus.req_store, bus.req_funct3);
`else
    assign crossing   = 1'b0;
    assign req_reject = funct3_illegal(bus.req_store, bus.req_funct3) ||
                        misaligned(bus.req_funct3, bus.req_addr[1:0]);
`endif

    always_comb begin
        state_d      = state_q;
        store_d      = store_q;
        f3_d         = f3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        lo_d         = lo_q;
        resp_valid_d = resp_valid_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    store_d = bus.req_store;
                    f3_d    = bus.req_funct3;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    if (req_reject) begin
                        state_d      = DONE;
                        resp_valid_d = 1'b1;
                        err_d        = 1'b1;
                        rdata_d      = '0;
                    end else begin
                        state_d = ACC0;
                    end
                end
            end
            ACC0, ACC1: begin
                if (state_q == ACC0) begin
                    lo_d = bus.dram_dout;
                end
                if ((state_q == ACC0) && crossing) begin
                    state_d = ACC1;
                end else begin
                    state_d      = DONE;
                    resp_valid_d = 1'b1;
                    err_d        = 1'b0;
                    rdata_d      = store_q ? '0 : rdata_ext;
                end
            end
            DONE: begin
                if (bus.resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request fields and the low read word carry no reset; they are only
    // consumed after a handshake has written them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
        store_q <= store_d;
        f3_q    <= f3_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        lo_q    <= lo_d;
    end

    // RAM port decode. Reset masks the strobes immediately so an access
    // cycle that coincides with reset never reaches the RAM.
    always_comb begin
        bus.dram_addr    = '0;
        bus.dram_wdat    = '0;
        bus.dram_we      = 1'b0;
        bus.dram_we_byte = 4'd0;
        bus.dram_rd      = 1'b0;
        if (!rst) begin
            case (state_q)
                ACC0: begin
                    bus.dram_addr = word_addr;
                    if (store_q) begin
                        bus.dram_we      = 1'b1;
                        bus.dram_we_byte = lane_mask[3:0];
                        bus.dram_wdat    = wdata_sh[31:0];
                    end else begin
                        bus.dram_rd = 1'b1;
                    end
                end
                ACC1: begin
                    bus.dram_addr = word_addr + AW'(4);
                    if (store_q) begin
                        bus.dram_we      = 1'b1;
                        bus.dram_we_byte = lane_mask[7:4];
                        bus.dram_wdat    = wdata_sh[63:32];
                    end else begin
                        bus.dram_rd = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
`timescale 1ns/1ps
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic fill_ram;
    always #5 clk = ~clk;

    lsu_ctrl_if #(.AW(32), .DW(32)) bus ();

    lsu_ctrl #(.AW(32), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Word RAM seen by the DUT (256 bytes, aliased on address bits [7:2]).
    logic [7:0]  ram_b [0:255];
    logic [7:0]  mem_m [0:255];   // reference byte memory
    logic [7:0]  wbase;
    int          acc_cnt = 0;
    int          strobe_viol = 0;
    logic [31:0] log_addr [0:1023];
    logic [3:0]  log_wb   [0:1023];
    logic [31:0] log_wd   [0:1023];

    assign wbase = {bus.dram_addr[7:2], 2'b00};
    assign bus.dram_dout = {ram_b[wbase + 8'd3], ram_b[wbase + 8'd2],
                            ram_b[wbase + 8'd1], ram_b[wbase]};

    always @(posedge clk) begin
        if (fill_ram) begin
            for (int i = 0; i < 256; i++) ram_b[i] <= 8'(i * 37 + 11);
        end else if (bus.dram_we) begin
            for (int l = 0; l < 4; l++)
                if (bus.dram_we_byte[l]) ram_b[wbase + 8'(l)] <= bus.dram_wdat[8*l +: 8];
        end
        if (bus.dram_we || bus.dram_rd) begin
            log_addr[acc_cnt % 1024] <= bus.dram_addr;
            log_wb[acc_cnt % 1024]   <= bus.dram_we_byte;
            log_wd[acc_cnt % 1024]   <= bus.dram_wdat;
            acc_cnt <= acc_cnt + 1;
        end
    end

    // No RAM strobe may be active while idle or holding a response.
    always @(negedge clk) begin
        if ((bus.req_ready || bus.resp_valid) &&
            (bus.dram_we || bus.dram_rd || bus.dram_we_byte != 4'd0))
            strobe_viol <= strobe_viol + 1;
    end

    function automatic int ram_diff();
        int n = 0;
        for (int i = 0; i < 256; i++) if (ram_b[i] !== mem_m[i]) n++;
        return n;
    endfunction

    // Reference model: byte-level view of one transaction.
    function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd,
                                  output logic er, output int lat, output int acc);
        int size, off;
        logic illegal;
        logic [31:0] v, ba;
        rd = 0; er = 0; lat = 1; acc = 0;
        illegal = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off = int'(a[1:0]);
        if (illegal) begin er = 1; return; end
`ifndef LSU_MISALIGN_SPLIT_EN
        if (off % size != 0) begin er = 1; return; end
`endif
        lat = (off + size > 4) ? 3 : 2;
        acc = (off + size > 4) ? 2 : 1;
        v = 0;
        for (int i = 0; i < size; i++) begin
            ba = a + 32'(i);
            if (st) mem_m[ba[7:0]] = wd[8*i +: 8];
            else    v[8*i +: 8] = mem_m[ba[7:0]];
        end
        if (!st) begin
            if (f3 == F3_B) v = {{24{v[7]}}, v[7:0]};
            if (f3 == F3_H) v = {{16{v[15]}}, v[15:0]};
            rd = v;
        end
    endfunction

    task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int stall,
                           output logic [31:0] rd, output logic [31:0] rd2, output logic er,
                           output int lat, output int acc, output int first, output bit tmo);
        int w = 0;
        tmo = 0;
        @(negedge clk);
        while (!bus.req_ready && w < 20) begin @(negedge clk); w++; end
        if (!bus.req_ready) tmo = 1;
        first = acc_cnt;
        bus.req_valid = 1; bus.req_store = st; bus.req_funct3 = f3;
        bus.req_addr = a; bus.req_wdata = wd;
        @(posedge clk); #1;
        bus.req_valid = 0; bus.req_addr = $urandom(); bus.req_wdata = $urandom();
        bus.req_funct3 = 3'($urandom()); bus.req_store = 1'($urandom());
        lat = 1;
        while (!bus.resp_valid && lat < 12) begin @(posedge clk); #1; lat++; end
        if (!bus.resp_valid) tmo = 1;
        rd = bus.resp_rdata; er = bus.resp_err; acc = acc_cnt - first;
        repeat (stall) begin @(posedge clk); #1; end
        rd2 = bus.resp_rdata;
        bus.resp_ready = 1;
        @(posedge clk); #1;
        bus.resp_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1; fill_ram = 1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
        checks++;
        if ({bus.resp_valid, bus.resp_err} !== 2'b00) begin errors++; $display("FAIL reset_resp got=%b%b exp=00", bus.resp_valid, bus.resp_err); end
        checks++;
        if (bus.resp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", bus.resp_rdata); end
        checks++;
        if ({bus.dram_we, bus.dram_rd, bus.dram_we_byte} !== 6'd0 || bus.dram_addr !== 32'd0) begin
            errors++; $display("FAIL reset_dram got we=%b rd=%b wb=%b addr=%h exp all 0", bus.dram_we, bus.dram_rd, bus.dram_we_byte, bus.dram_addr);
        end
        fill_ram = 0; rst = 0;
        @(posedge clk); #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_req_ready got=%b exp=1", bus.req_ready); end
    endtask

    task automatic test_aligned();
        logic [31:0] rd, rd2, erd; logic er, eer; int lat, acc, elat, eacc, first; bit tmo;
        model(1, F3_W, 32'h10, 32'hDEADBEEF, erd, eer, elat, eacc);
        run_txn(1, F3_W, 32'h10, 32'hDEADBEEF, 0, rd, rd2, er, lat, acc, first, tmo);
        checks++;
        if (tmo || lat != 2 || acc != 1 || er !== 1'b0) begin errors++; $display("FAIL sw_aligned got tmo=%0d lat=%0d acc=%0d err=%b exp 0/2/1/0", tmo, lat, acc, er); end
        checks++;
        if (log_addr[first % 1024] !== 32'h10 || log_wb[first % 1024] !== 4'hF || log_wd[first % 1024] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL sw_aligned_bus got addr=%h wb=%h wd=%h exp 10/f/deadbeef", log_addr[first % 1024], log_wb[first % 1024], log_wd[first % 1024]);
        end
        model(0, F3_W, 32'h10, 32'h0, erd, eer, elat, eacc);
        run_txn(0, F3_W, 32'h10, 32'h0, 0, rd, rd2, er, lat, acc, first, tmo);
        checks++;
        if (tmo || rd !== 32'hDEADBEEF || lat != 2 || er !== 1'b0) begin errors++; $display("FAIL lw_aligned got rd=%h lat=%0d err=%b exp deadbeef/2/0", rd, lat, er); end
    endtask

    task automatic test_byte_sign();
        logic [31:0] rd, rd2, erd; logic er, eer; int lat, acc, elat, eacc, first; bit tmo;
        model(1, F3_B, 32'h21, 32'h00000080, erd, eer, elat, eacc);
        run_txn(1, F3_B, 32'h21, 32'h00000080, 0, rd, rd2, er, lat, acc, first, tmo);
        checks++;
        if (tmo || acc != 1 || log_wb[first % 1024] !== 4'b0010 || log_wd[first % 1024][15:8] !== 8'h80) begin
            errors++; $display("FAIL sb_lane got acc=%0d wb=%b wd=%h exp 1/0010/..80..", acc, log_wb[first % 1024], log_wd[first % 1024]);
        end
        model(0, F3_B, 32'h21, 32'h0, erd, eer, elat, eacc);
        run_txn(0, F3_B, 32'h21, 32'h0, 0, rd, rd2, er, lat, acc, first, tmo);
        checks++;
        if (tmo || rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_sign got=%h exp=ffffff80", rd); end
        model(0, F3_BU, 32'h21, 32'h0, erd, eer, elat, eacc);
        run_txn(0, F3_BU, 32'h21, 32'h0, 0, rd, rd2, er, lat, acc, first, tmo);
        checks++;
        if (tmo || rd !== 32'h00000080) begin errors++; $display("FAIL lbu_zero got=%h exp=00000080", rd); end
    endtask

    task automatic test_crossing();
        logic [31:0] rd, rd2, erd; logic er, eer; int lat, acc, elat, eacc, first; bit tmo;
        model(1, F3_W, 32'h33, 32'h11223344, erd, eer, elat, eacc);
        run_txn(1, F3_W, 32'h33, 32'h11223344, 0, rd, rd2, er, lat, acc, first, tmo);
`ifdef LSU_MISALIGN_SPLIT_EN
        checks++;
        if (tmo || lat != 3 || acc != 2 || er !== 1'b0) begin errors++; $display("FAIL sw_cross got lat=%0d acc=%0d err=%b exp 3/2/0", lat, acc, er); end
        checks++;
        if (log_addr[first % 1024] !== 32'h30 || log_wb[first % 1024] !== 4'b1000 || log_wd[first % 1024][31:24] !== 8'h44) begin
            errors++; $display("FAIL sw_cross_acc0 got addr=%h wb=%b wd=%h exp 30/1000/44......", log_addr[first % 1024], log_wb[first % 1024], log_wd[first % 1024]);
        end
        checks++;
        if (log_addr[(first + 1) % 1024] !== 32'h34 || log_wb[(first + 1) % 1024] !== 4'b0111 || log_wd[(first + 1) % 1024][23:0] !== 24'h112233) begin
            errors++; $display("FAIL sw_cross_acc1 got addr=%h wb=%b wd=%h exp 34/0111/..112233", log_addr[(first + 1) % 1024], log_wb[(first + 1) % 1024], log_wd[(first + 1) % 1024]);
        end
        model(0, F3_W, 32'h33, 32'h0, erd, eer, elat, eacc);
        run_txn(0, F3_W, 32'h33, 32'h0, 0, rd, rd2, er, lat, acc, first, tmo);
        checks++;
        if (tmo || rd !== 32'h11223344 || lat != 3) begin errors++; $display("FAIL lw_cross got rd=%h lat=%0d exp 11223344/3", rd, lat); end
        model(1, F3_W, 32'hFFFFFFFE, 32'hA5B6C7D8, erd, eer, elat, eacc);
        run_txn(1, F3_W, 32'hFFFFFFFE, 32'hA5B6C7D8, 0, rd, rd2, er, lat, acc, first, tmo);
        checks++;
        if (tmo || log_addr[first % 1024] !== 32'hFFFFFFFC || log_addr[(first + 1) % 1024] !== 32'h0) begin
            errors++; $display("FAIL cross_wrap got a0=%h a1=%h exp fffffffc/0", log_addr[first % 1024], log_addr[(first + 1) % 1024]);
        end
`else
        checks++;
        if (tmo || er !== 1'b1 || lat != 1 || acc != 0) begin errors++; $display("FAIL sw_cross_reject got err=%b lat=%0d acc=%0d exp 1/1/0", er, lat, acc); end
        model(0, F3_W, 32'h33, 32'h0, erd, eer, elat, eacc);
        run_txn(0, F3_W, 32'h33, 32'h0, 0, rd, rd2, er, lat, acc, first, tmo);
        checks++;
        if (tmo || er !== 1'b1 || rd !== 32'h0 || acc != 0) begin errors++; $display("FAIL lw_cross_reject got err=%b rd=%h acc=%0d exp 1/0/0", er, rd, acc); end
`endif
        checks++;
        if (ram_diff() != 0) begin errors++; $display("FAIL cross_ram got %0d differing bytes exp 0", ram_diff()); end
    endtask

    task automatic test_misalign();
        logic [31:0] rd, rd2, erd; logic er, eer; int lat, acc, elat, eacc, first; bit tmo;
        model(0, F3_H, 32'h41, 32'h0, erd, eer, elat, eacc);
        run_txn(0, F3_H, 32'h41, 32'h0, 0, rd, rd2, er, lat, acc, first, tmo);
        checks++;
        if (tmo || er !== eer || lat != elat || acc != eacc || rd !== erd) begin
            errors++; $display("FAIL lh_misalign got err=%b lat=%0d acc=%0d rd=%h exp %b/%0d/%0d/%h", er, lat, acc, rd, eer, elat, eacc, erd);
        end
        model(1, F3_H, 32'h47, 32'h0000BEEF, erd, eer, elat, eacc);
        run_txn(1, F3_H, 32'h47, 32'h0000BEEF, 0, rd, rd2, er, lat, acc, first, tmo);
        checks++;
        if (tmo || er !== eer || lat != elat || acc != eacc || ram_diff() != 0) begin
            errors++; $display("FAIL sh_misalign got err=%b lat=%0d acc=%0d exp %b/%0d/%0d", er, lat, acc, eer, elat, eacc);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd, rd2, erd; logic er, eer; int lat, acc, elat, eacc, first; bit tmo;
        @(negedge clk);
        bus.req_valid = 1; bus.req_store = 0; bus.req_funct3 = 3'd3; bus.req_addr = 32'h50;
        @(posedge clk); #1;
        // keep a legal request pending; it must be ignored while DONE holds
        bus.req_funct3 = F3_W;
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1 || bus.resp_rdata !== 32'd0) begin
            errors++; $display("FAIL illegal_f3 got v=%b err=%b rd=%h exp 1/1/0", bus.resp_valid, bus.resp_err, bus.resp_rdata);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1 || bus.resp_rdata !== 32'd0 || bus.req_ready !== 1'b0) begin
                errors++; $display("FAIL hold_%0d got v=%b err=%b rd=%h rdy=%b exp 1/1/0/0", c, bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.req_ready);
            end
        end
        bus.req_valid = 0; bus.resp_ready = 1;
        @(posedge clk); #1;
        bus.resp_ready = 0;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            errors++; $display("FAIL release got rdy=%b v=%b exp 1/0", bus.req_ready, bus.resp_valid);
        end
        model(0, F3_HU, 32'h12, 32'h0, erd, eer, elat, eacc);
        run_txn(0, F3_HU, 32'h12, 32'h0, 4, rd, rd2, er, lat, acc, first, tmo);
        checks++;
        if (tmo || rd !== erd || rd2 !== erd) begin errors++; $display("FAIL load_hold got rd=%h rd_after=%h exp %h", rd, rd2, erd); end
    endtask

    task automatic test_reset_midop();
        logic [31:0] wd;
        int w;
        wd = $urandom();
        @(negedge clk);
        bus.req_valid = 1; bus.req_store = 1; bus.req_funct3 = F3_W; bus.req_wdata = wd;
`ifdef LSU_MISALIGN_SPLIT_EN
        bus.req_addr = 32'h53;
        @(posedge clk); #1;                   // ACC0
        bus.req_valid = 0;
        mem_m[8'h53] = wd[7:0];               // first half commits
        @(posedge clk); #1;                   // ACC1
`else
        bus.req_addr = 32'h54;
        @(posedge clk); #1;                   // ACC0
        bus.req_valid = 0;
`endif
        rst = 1; #1;
        checks++;
        if (bus.dram_we !== 1'b0) begin errors++; $display("FAIL midop_we got=%b exp=0", bus.dram_we); end
        @(posedge clk); #1;
        rst = 0;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            errors++; $display("FAIL midop_idle got rdy=%b v=%b exp 1/0", bus.req_ready, bus.resp_valid);
        end
        w = 0;
        repeat (4) begin @(posedge clk); #1; if (bus.resp_valid) w++; end
        checks++;
        if (w != 0) begin errors++; $display("FAIL midop_noresp got %0d valid cycles exp 0", w); end
        checks++;
        if (ram_diff() != 0) begin errors++; $display("FAIL midop_ram got %0d differing bytes exp 0", ram_diff()); end
    endtask

    task automatic test_random(input int n, input bit stalls);
        logic [31:0] rd, rd2, erd, a, wd; logic er, eer, st; logic [2:0] f3;
        int lat, acc, elat, eacc, first, idx, stall, bad; bit tmo;
        logic [2:0] legal_t [0:4];
        logic [2:0] illegal_t [0:2];
        legal_t = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
        illegal_t = '{3'd3, 3'd6, 3'd7};
        bad = 0;
        for (int k = 0; k < n; k++) begin
            st = 1'($urandom());
            idx = $urandom_range(0, 15);
            f3 = (idx < 13) ? legal_t[idx % 5] : illegal_t[idx - 13];
            a = $urandom();
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            wd = $urandom();
            stall = stalls ? $urandom_range(0, 3) : 0;
            model(st, f3, a, wd, erd, eer, elat, eacc);
            run_txn(st, f3, a, wd, stall, rd, rd2, er, lat, acc, first, tmo);
            checks++;
            if (tmo || rd !== erd || rd2 !== erd || er !== eer || lat != elat || acc != eacc) begin
                errors++;
                $display("FAIL rand_%0d st=%b f3=%0d a=%h got rd=%h/%h err=%b lat=%0d acc=%0d tmo=%0d exp rd=%h err=%b lat=%0d acc=%0d",
                         k, st, f3, a, rd, rd2, er, lat, acc, tmo, erd, eer, elat, eacc);
            end
            if (ram_diff() != 0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rand_ram got %0d transactions with RAM differences exp 0", bad); end
    endtask

    initial begin
        rst = 1; fill_ram = 1;
        bus.req_valid = 0; bus.req_store = 0; bus.req_funct3 = 3'd0;
        bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.resp_ready = 0;
        for (int i = 0; i < 256; i++) mem_m[i] = 8'(i * 37 + 11);
        test_reset();
        test_aligned();
        test_byte_sign();
        test_crossing();
        test_misalign();
        test_backpressure();
        test_reset_midop();
        test_random(30, 1'b0);   // back-to-back, no response stalls
        test_random(250, 1'b1);
        checks++;
        if (strobe_viol != 0) begin errors++; $display("FAIL idle_strobes got %0d cycles with strobes exp 0", strobe_viol); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit sitting directly upstream of the data RAM (`dram`); consumes the EX-stage memory request and produces the data-RAM access plus a registered, extended load result for writeback.
- Converts RV32 load/store `funct3` plus byte address into word-aligned `dram_addr`, `dram_we_byte`, shifted `dram_wdat`, and `dram_rd`.
- Splits word-crossing accesses into two sequential word accesses.

Parameters:
- `AW`, 32, byte-address width.
- `DW`, 32, data width; only 32 is supported.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid` and `req_ready` are both high.
- `req_store`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32 width/sign code: 0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU.
- `req_addr`  in  AW  byte address.
- `req_wdata`  in  DW  store data, LSB-justified.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer takes result.
- `resp_rdata`  out  DW  extended load data; 0 for stores.
- `resp_err`  out  1  illegal `funct3` or unsupported misalignment.
- `dram_addr`  out  AW  word-aligned byte address.
- `dram_wdat`  out  DW  byte-lane-positioned write data.
- `dram_we`  out  1  write strobe.
- `dram_we_byte`  out  4  byte-lane enables.
- `dram_rd`  out  1  read enable; the RAM returns `dram_dout` combinationally in the same cycle.
- `dram_dout`  in  DW  RAM read data.

Behaviour:
- States: IDLE, ACC0, ACC1, DONE.
- Reset (synchronous, `rst`=1 at a clock edge):
  - state goes to IDLE.
  - `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
  - `req_ready`=1.
  - All `dram_*` strobes are 0 and `dram_addr`=0.
- IDLE:
  - `req_ready`=1.
  - On handshake, latch store flag, `funct3`, address, and wdata; compute `off`=addr[1:0] and size (1, 2 or 4).
  - Illegal `funct3` (loads 3/6/7; stores greater than 2) goes to DONE with `err`=1 and no RAM access.
  - Otherwise go to ACC0.
- ACC0:
  - `dram_addr` = addr & ~3.
  - 8-bit lane mask M = ((1<<size)-1) << off.
  - 64-bit shifted data S = wdata << (8*off).
  - Store: `dram_we`=1, `dram_we_byte`=M[3:0], `dram_wdat`=S[31:0].
  - Load: `dram_rd`=1; capture `dram_dout` into lo.
  - If M[7:4] != 0, go to ACC1; else go to DONE.
- ACC1:
  - `dram_addr` = (addr & ~3) + 4, modulo 2^AW (wraps to 0).
  - Store: `dram_we_byte`=M[7:4], `dram_wdat`=S[63:32].
  - Load: capture hi.
  - Go to DONE.
- DONE (entry):
  - Load: `rdata` = ({hi,lo} >> 8*off), truncated to size, then sign-extended for B/H or zero-extended for BU/HU.
  - Store: `rdata`=0.
  - `resp_valid`=1; hold `rdata`/`err` stable until `resp_ready`, then go to IDLE.
  - `req_ready`=0 here, so no same-cycle re-acceptance.
- Latency from accept edge to `resp_valid`:
  - aligned/non-crossing: 2 cycles.
  - crossing: 3 cycles.
  - error: 1 cycle.
- Stalls:
  - `req_valid` is ignored outside IDLE.
  - All `dram_*` strobes are 0 in IDLE and DONE.
- Reset mid-operation: abort and return to IDLE. A store half already written in ACC0 remains committed. No response is issued.
- RAM range is not checked; addresses beyond RAM depth alias per RAM decoding.

Optional Feature:
- Macro `LSU_MISALIGN_SPLIT_EN`.
- Defined: behaviour as above, with crossing accesses split across ACC0/ACC1.
- Undefined:
  - Any access with `off` % size != 0 goes IDLE→DONE with `resp_err`=1 and no RAM access.
  - ACC1 is unreachable and may be optimised away.

Decomposition:
- Package `lsu_pkg`: `funct3` constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`) and the state enum `lsu_state_t`.
- One combinational sub-module `lsu_align`:
  - store path: lane mask and shifted data.
  - load path: {hi,lo}, `off`, `funct3` → extended result.

Test Plan:
- Aligned word: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → `we_byte`=4'hF; load `rdata`=0xDEADBEEF, `resp_valid` 2 cycles after accept.
- Byte sign: SB addr 0x21 data 0x80, then LB 0x21 → `we_byte`=4'b0010, `wdat`[15:8]=0x80; LB returns 0xFFFFFF80, LBU returns 0x00000080.
- Crossing: SW addr 0x33 data 0x11223344 → ACC0 word 0x30 lanes 4'b1000 byte 0x44; ACC1 word 0x34 lanes 4'b0111; LW 0x33 returns 0x11223344 after 3 cycles.
- Misalign without macro: LH addr 0x41 → `resp_err`=1 after 1 cycle; `dram_rd`/`dram_we` never asserted.
- Illegal/backpressure: load `funct3`=3 → `err`=1. Hold `resp_ready`=0 for 5 cycles → `rdata`/`err` stable and `req_ready`=0; release → IDLE next cycle.
- Reset mid-op: crossing SW, `rst` high during ACC1 → no ACC1 write, no `resp_valid`, `req_ready`=1 the cycle after reset.
